gray_decoder: RTL

Receive-side companion to the team's Gray-code counter. Samples a WIDTH-bit Gray-coded value on each enabled cycle, converts it to binary, and checks that successive samples form a legal Gray sequence. It counts full-cycle wraps and latches a sticky fault on any illegal transition. It sits at the consuming end of a Gray-coded count path, such as a counter crossing a domain or a position encoder, and presents a checked binary value to downstream logic.

---
 rtl/gray_decoder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/gray_decoder.sv
// gray_decoder: samples a Gray-coded count, converts it to binary and
// checks that successive samples form a legal Gray sequence.
// Counts forward wraps (MAX -> 0) and latches a sticky fault on any
// illegal transition.
//
// Optional feature: define GRAY_DECODER_BIDIR_EN to accept backward
// motion (d == p-1, and reverse wrap 0 -> MAX which decrements WrapCnt).
// Without it, backward motion is treated as an illegal transition.
//
// DbgState exposes the FSM state (0 IDLE, 1 TRACK, 2 FAULT).
module gray_decoder #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic [WIDTH-1:0] Gray,
    output logic [WIDTH-1:0] Binary,
    output logic             Valid,
    output logic [CNT_W-1:0] WrapCnt,
    output logic             Overflow,
    output logic             Error,
    output logic [1:0]       DbgState
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX_V   = '1;
    localparam logic [WIDTH-1:0] ZERO_V  = '0;
    localparam logic [WIDTH-1:0] ONE_V   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [CNT_W-1:0] wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] p_inc;
`ifdef GRAY_DECODER_BIDIR_EN
    logic [WIDTH-1:0] p_dec;
`endif

    // Gray-to-binary decode: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        dec = '0;
        dec[WIDTH-1] = Gray[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            dec[i] = dec[i+1] ^ Gray[i];
        end
    end

    assign p_inc = bin_q + ONE_V;
`ifdef GRAY_DECODER_BIDIR_EN
    assign p_dec = bin_q - ONE_V;
`endif

    // Next-state and datapath update: classify the decoded sample against the held value.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        wrap_d  = wrap_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                // First sample after reset is accepted without a check.
                if (En) begin
                    bin_d   = dec;
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (En) begin
                    if (dec == bin_q) begin
                        // Stall: legal, nothing changes.
                    end else if (bin_q != MAX_V && dec == p_inc) begin
                        bin_d = dec;
                    end else if (bin_q == MAX_V && dec == ZERO_V) begin
                        bin_d  = ZERO_V;
                        wrap_d = wrap_q + CNT_ONE;
                        ovf_d  = 1'b1;
`ifdef GRAY_DECODER_BIDIR_EN
                    end else if (bin_q != ZERO_V && dec == p_dec) begin
                        bin_d = dec;
                    end else if (bin_q == ZERO_V && dec == MAX_V) begin
                        bin_d  = MAX_V;
                        wrap_d = wrap_q - CNT_ONE;
`endif
                    end else begin
                        // Illegal value is not loaded; the last good value is kept.
                        state_d = FAULT;
                        err_d   = 1'b1;
                    end
                end
            end
            FAULT: begin
                // Absorbing: everything frozen until Reset.
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; Reset wins over En from any state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            wrap_q  <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign Binary   = bin_q;
    assign Valid    = (state_q == TRACK);
    assign WrapCnt  = wrap_q;
    assign Overflow = ovf_q;
    assign Error    = err_q;
    assign DbgState = state_q;

endmodule
